// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and registered read port
module uart_tx_mmio #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] io_rdata,
    output logic        io_sel,
    output logic        txd,
    output logic        tx_busy
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   COUNT_ONE = (PW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          overflow;

    logic [5:0]  offset;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        ovf_clear;
    logic [31:0] rdata_next;
    logic        unused_bits;

    assign io_sel    = mem_addr[22];
    assign offset    = mem_addr[7:2];
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign push_req  = io_sel && mem_wmask[0] && (offset == 6'd0);
    assign push      = push_req && !full;
    // Pop only sees bytes present before this edge, so a fresh push waits one cycle.
    assign pop       = (state == IDLE) && !empty;
    assign ovf_clear = io_sel && (|mem_wmask) && (offset == 6'd1) && mem_wdata[3];
    assign tx_busy   = (state != IDLE) || !empty;
    assign unused_bits = ^{mem_addr[31:23], mem_addr[21:8], mem_addr[1:0], mem_wdata[31:8]};

    always_comb begin
        rdata_next = 32'd0;
        case (offset)
            6'd1: rdata_next = {24'd0, 4'(count), overflow, (state != IDLE), empty, full};
            6'd2: rdata_next = 32'(DIV);
            default: rdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            io_rdata <= 32'd0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + COUNT_ONE;
            end else if (pop && !push) begin
                count <= count - COUNT_ONE;
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
            if (mem_rstrb && io_sel) begin
                io_rdata <= rdata_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg    <= fifo_mem[rptr];
                        txd      <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= START;
                    end else begin
                        txd <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= '0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio (DIV=10, depth 4)
module tb_uart_tx_mmio;
    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] io_rdata;
    logic        io_sel;
    logic        txd;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    uart_tx_mmio #(
        .CLK_FREQ_HZ(1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb),
        .io_rdata (io_rdata),
        .io_sel   (io_sel),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the store occupies the next rising edge.
    task automatic store(input logic [31:0] addr, input logic [7:0] data);
        mem_addr  = addr;
        mem_wdata = {4{data}};
        mem_wmask = 4'b0001;
        mem_rstrb = 1'b0;
        @(negedge clk);
        mem_wmask = 4'b0000;
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        data = io_rdata;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Samples txd once per cycle from frame cycle j0 up to 99, then checks the idle-high cycle 100.
    task automatic check_frame(input logic [7:0] b, input int j0, input bit with_reads);
        for (int j = j0; j < 100; j++) begin
            check($sformatf("frame_%02h_c%0d", b, j), {31'd0, txd}, {31'd0, frame_bit(b, j / 10)});
            if (with_reads && j == 40) begin
                mem_addr  = 32'h0040_0004;
                mem_rstrb = 1'b1;
            end else if (with_reads && j == 41) begin
                check("status_mid_frame", io_rdata, 32'h0000_0006);
                mem_addr = 32'h0040_0008;
            end else if (with_reads && j == 42) begin
                check("baud_div", io_rdata, 32'd10);
                mem_rstrb = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("frame_%02h_end", b), {31'd0, txd}, 32'd1);
    endtask

    logic [31:0] rd;
    bit          seen_low;

    initial begin
        reset     = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wmask = 4'd0;
        mem_rstrb = 1'b0;

        #3 reset = 1'b1;
        #1;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_rdata", io_rdata, 32'd0);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_reg(32'h0040_0004, rd);
        check("reset_status", rd, 32'h0000_0002);

        store(32'h0040_0000, 8'h55);
        check("no_same_edge_pop", {31'd0, txd}, 32'd1);
        check("busy_after_push", {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        check_frame(8'h55, 0, 1'b1);
        check("single_busy_done", {31'd0, tx_busy}, 32'd0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            store(32'h0040_0000, 8'h41 + 8'(i));
        end
        read_reg(32'h0040_0004, rd);
        check("status_overflow", rd, 32'h0000_004D);
        store(32'h0040_0004, 8'h08);
        read_reg(32'h0040_0004, rd);
        check("status_ovf_cleared", rd, 32'h0000_0045);
        check_frame(8'h41, 7, 1'b0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check_frame(8'h41 + 8'(i), 0, 1'b0);
        end
        check("ovf_busy_done", {31'd0, tx_busy}, 32'd0);
        seen_low = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (txd == 1'b0) seen_low = 1'b1;
        end
        check("dropped_byte_not_sent", {31'd0, seen_low}, 32'd0);

        store(32'h0040_0000, 8'h00);
        store(32'h0040_0000, 8'h12);
        store(32'h0040_0000, 8'h34);
        repeat (34) @(negedge clk);
        check("pre_reset_low", {31'd0, txd}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("midframe_reset_txd", {31'd0, txd}, 32'd1);
        check("midframe_reset_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_reg(32'h0040_0004, rd);
        check("post_reset_status", rd, 32'h0000_0002);
        seen_low = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (txd == 1'b0 || tx_busy == 1'b1) seen_low = 1'b1;
        end
        check("no_frames_after_reset", {31'd0, seen_low}, 32'd0);

        mem_addr = 32'h0000_0000;
        #1;
        check("io_sel_low", {31'd0, io_sel}, 32'd0);
        mem_addr = 32'h0040_0000;
        #1;
        check("io_sel_high", {31'd0, io_sel}, 32'd1);
        @(negedge clk);
        store(32'h0000_0000, 8'hAA);
        store(32'h0040_000C, 8'hAA);
        repeat (3) @(negedge clk);
        check("decode_txd", {31'd0, txd}, 32'd1);
        check("decode_busy", {31'd0, tx_busy}, 32'd0);
        read_reg(32'h0040_0008, rd);
        check("baud_div_again", rd, 32'd10);
        read_reg(32'h0000_0004, rd);
        check("unselected_read_holds", rd, 32'd10);
        read_reg(32'h0040_000C, rd);
        check("offset_0c_reads_0", rd, 32'd0);
        read_reg(32'h0040_0008, rd);
        read_reg(32'h0040_0000, rd);
        check("tx_data_reads_0", rd, 32'd0);
        read_reg(32'h0040_0004, rd);
        check("decode_status", rd, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
